// File: rtl/picorv32_core.sv
// rtl/picorv32_core.sv - multi-cycle RV32I core on a shared valid/ready bus; optional interrupts via PICORV32_IRQ_EN
module picorv32_core #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter logic [31:0] PROGADDR_IRQ   = 32'h0000_0010,
    parameter logic [31:0] MASKED_IRQ     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        trap,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] irq,
    output logic [31:0] eoi
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;
    state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] regs [0:31];
    logic [1:0]  ls_off;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, exec_wb, pc_next, ls_addr;
    logic [31:0] st_data, ld_word, ld_data, rf_wdata;
    logic [3:0]  st_strb;
    logic        br_take, illegal, is_load, is_store, exec_we;
    logic        ls_misalign, exec_trap, rf_we;

`ifdef PICORV32_IRQ_EN
    localparam logic [31:0] MRET_INSN = 32'h3020_0073;
    logic        irq_active;
    logic [31:0] irq_retpc;
    logic [31:0] irq_pending;
    logic        irq_take;
    logic        is_mret;
    assign irq_pending = irq & ~MASKED_IRQ;
    assign irq_take    = (state == S_FETCH) && !mem_valid && (irq_pending != 32'd0) && !irq_active;
`else
    logic unused_irq;
    assign unused_irq = ^{irq, PROGADDR_IRQ, MASKED_IRQ};
    assign eoi = 32'd0;
`endif

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign f7     = insn[31:25];
    assign rs1v   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u  = {insn[31:12], 12'd0};
    assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    // ALU shared by OP and OP-IMM; SUB only exists in the register form
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2v : imm_i;
        case (f3)
            3'd0:    alu_y = ((opcode == OP_REG) && insn[30]) ? rs1v - alu_b : rs1v + alu_b;
            3'd1:    alu_y = rs1v << alu_b[4:0];
            3'd2:    alu_y = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'd3:    alu_y = {31'd0, rs1v < alu_b};
            3'd4:    alu_y = rs1v ^ alu_b;
            3'd5:    alu_y = insn[30] ? $unsigned($signed(rs1v) >>> alu_b[4:0]) : rs1v >> alu_b[4:0];
            3'd6:    alu_y = rs1v | alu_b;
            default: alu_y = rs1v & alu_b;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        case (f3)
            3'd0:    br_take = rs1v == rs2v;
            3'd1:    br_take = rs1v != rs2v;
            3'd4:    br_take = $signed(rs1v) <  $signed(rs2v);
            3'd5:    br_take = $signed(rs1v) >= $signed(rs2v);
            3'd6:    br_take = rs1v <  rs2v;
            3'd7:    br_take = rs1v >= rs2v;
            default: br_take = 1'b0;
        endcase
    end

    // Instruction decode: legality, writeback value, next PC and memory-access intent
    always_comb begin
        illegal  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        exec_we  = 1'b0;
        exec_wb  = alu_y;
        pc_next  = pc + 32'd4;
`ifdef PICORV32_IRQ_EN
        is_mret  = 1'b0;
`endif
        case (opcode)
            OP_LUI:   begin exec_we = 1'b1; exec_wb = imm_u; end
            OP_AUIPC: begin exec_we = 1'b1; exec_wb = pc + imm_u; end
            OP_JAL:   begin exec_we = 1'b1; exec_wb = pc + 32'd4; pc_next = pc + imm_j; end
            OP_JALR: begin
                illegal = (f3 != 3'd0);
                exec_we = 1'b1;
                exec_wb = pc + 32'd4;
                pc_next = (rs1v + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                illegal = (f3 == 3'd2) || (f3 == 3'd3);
                if (br_take) pc_next = pc + imm_b;
            end
            OP_LOAD: begin
                is_load = 1'b1;
                illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OP_STORE: begin
                is_store = 1'b1;
                illegal  = (f3 > 3'd2);
            end
            OP_IMM: begin
                exec_we = 1'b1;
                if (f3 == 3'd1) illegal = (f7 != 7'd0);
                if (f3 == 3'd5) illegal = (f7 != 7'd0) && (f7 != 7'b0100000);
            end
            OP_REG: begin
                exec_we = 1'b1;
                illegal = (f7 != 7'd0) && !((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            OP_FENCE: illegal = (f3 > 3'd1);
            OP_SYSTEM: begin
`ifdef PICORV32_IRQ_EN
                if (insn == MRET_INSN) begin
                    is_mret = 1'b1;
                    pc_next = irq_retpc;
                end else begin
                    illegal = 1'b1;
                end
`else
                illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

    // Load/store address, lane-replicated store data and byte strobes
    always_comb begin
        ls_addr = rs1v + (is_store ? imm_s : imm_i);
        case (f3[1:0])
            2'd0: begin
                st_data = {4{rs2v[7:0]}};
                st_strb = 4'b0001 << ls_addr[1:0];
            end
            2'd1: begin
                st_data = {2{rs2v[15:0]}};
                st_strb = ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = rs2v;
                st_strb = 4'b1111;
            end
        endcase
        ls_misalign = (is_load || is_store) &&
                      (((f3[1:0] == 2'd1) && ls_addr[0]) ||
                       ((f3[1:0] == 2'd2) && (ls_addr[1:0] != 2'd0)));
        exec_trap   = illegal || ls_misalign || (pc_next[1:0] != 2'd0);
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        ld_word = mem_rdata >> {ls_off, 3'b000};
        case (f3)
            3'd0:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4:    ld_data = {24'd0, ld_word[7:0]};
            3'd5:    ld_data = {16'd0, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    assign rf_we    = ((state == S_EXEC) && !exec_trap && exec_we) ||
                      ((state == S_MEM) && mem_valid && mem_ready && is_load);
    assign rf_wdata = (state == S_MEM) ? ld_data : exec_wb;

    // Register file write port; x0 is never written
    always_ff @(posedge clk) begin
        if (rf_we && (rd != 5'd0)) regs[rd] <= rf_wdata;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_FETCH;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: if (mem_valid && mem_ready) state_next = S_EXEC;
            S_EXEC: begin
                if (exec_trap)                state_next = S_TRAP;
                else if (is_load || is_store) state_next = S_MEM;
                else                          state_next = S_FETCH;
            end
            S_MEM:   if (mem_valid && mem_ready) state_next = S_FETCH;
            default: state_next = S_TRAP;
        endcase
    end

    // Bus master, PC, instruction latch, trap flag and interrupt bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc        <= PROGADDR_RESET;
            insn      <= 32'd0;
            ls_off    <= 2'd0;
            trap      <= 1'b0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
`ifdef PICORV32_IRQ_EN
            irq_active <= 1'b0;
            irq_retpc  <= 32'd0;
            eoi        <= 32'd0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b1;
                        mem_wstrb <= 4'd0;
                        mem_addr  <= pc;
`ifdef PICORV32_IRQ_EN
                        if (irq_take) begin
                            mem_addr   <= PROGADDR_IRQ;
                            pc         <= PROGADDR_IRQ;
                            irq_retpc  <= pc;
                            irq_active <= 1'b1;
                            eoi        <= irq_pending;
                        end
`endif
                    end else if (mem_ready) begin
                        insn      <= mem_rdata;
                        mem_valid <= 1'b0;
                        mem_instr <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (exec_trap) begin
                        trap <= 1'b1;
                    end else begin
                        pc <= pc_next;
`ifdef PICORV32_IRQ_EN
                        if (is_mret) begin
                            irq_active <= 1'b0;
                            eoi        <= 32'd0;
                        end
`endif
                        if (is_load || is_store) begin
                            mem_valid <= 1'b1;
                            mem_instr <= 1'b0;
                            mem_addr  <= {ls_addr[31:2], 2'b00};
                            mem_wstrb <= is_store ? st_strb : 4'd0;
                            mem_wdata <= is_store ? st_data : mem_wdata;
                            ls_off    <= ls_addr[1:0];
                        end
                    end
                end
                S_MEM: begin
                    if (mem_valid && mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'd0;
                    end
                end
                default: mem_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_core.sv
// tb/tb_picorv32_core.sv - directed self-checking bench for picorv32_core with RAM and UART model
module tb_picorv32_core;
    logic        clk = 1'b0;
    logic        resetn;
    logic        trap, mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, irq, eoi;
    logic [3:0]  mem_wstrb;

    picorv32_core dut (
        .clk(clk), .resetn(resetn), .trap(trap),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .irq(irq), .eoi(eoi)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] O_LUI = 7'b0110111, O_IMM = 7'b0010011, O_LOAD = 7'b0000011;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [31:0] ram [0:32767];
    logic [31:0] prog [$];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [3:0]  wr_strb [$];
    int          load_seq = 0, load_done = 0, proto_err = 0, wait_cnt = 0;
    logic        hold_valid = 1'b0, hold_instr;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_wstrb;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // RAM (ready two cycles after valid) + UART at 0x2000_0000 + handshake monitor
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_ready = 1'b0; wait_cnt = 0; hold_valid = 1'b0;
                if (load_done != load_seq) begin
                    for (int i = 0; i < 32768; i++) ram[i[14:0]] = 32'd0;
                    for (int i = 0; i < prog.size(); i++) ram[i[14:0]] = prog[i];
                    wr_addr.delete(); wr_data.delete(); wr_strb.delete();
                    load_done = load_seq;
                end
            end else if (mem_ready) begin
                if (mem_valid) proto_err++;
                mem_ready = 1'b0; wait_cnt = 0; hold_valid = 1'b0;
            end else if (mem_valid) begin
                if (hold_valid && (mem_addr !== hold_addr || mem_wdata !== hold_wdata ||
                                   mem_wstrb !== hold_wstrb || mem_instr !== hold_instr)) proto_err++;
                hold_valid = 1'b1; hold_addr = mem_addr; hold_wdata = mem_wdata;
                hold_wstrb = mem_wstrb; hold_instr = mem_instr;
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'd0;
                    if (mem_wstrb != 4'd0) begin
                        wr_addr.push_back(mem_addr);
                        wr_data.push_back(mem_wdata);
                        wr_strb.push_back(mem_wstrb);
                        if (mem_addr == 32'h2000_0000) begin
                            $display("UART: %c", mem_wdata[7:0]);
                        end else if (mem_addr[31:17] == 15'd0) begin
                            for (int b = 0; b < 4; b++)
                                if (mem_wstrb[b]) ram[mem_addr[16:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end else if (mem_addr[31:17] == 15'd0) begin
                        mem_rdata = ram[mem_addr[16:2]];
                    end
                end
            end
        end
    end

    task automatic add(input logic [31:0] w);
        prog.push_back(w);
    endtask

    task automatic start_run();
        resetn = 1'b0;
        irq = 32'd0;
        load_seq++;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run_until_trap(input string tag);
        int n = 0;
        while (!trap && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, trap}, 32'd1);
    endtask

    task automatic check_frozen(input string tag);
        int seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mem_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic next_fetch(output logic [31:0] addr, output logic ok);
        ok = 1'b0;
        addr = 32'hxxxx_xxxx;
        for (int n = 0; n < 200 && mem_valid; n++) @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            if (mem_valid && mem_instr) begin
                ok = 1'b1;
                addr = mem_addr;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn = 1'b0;
        irq = 32'd0;

        // UART write program, plus reset values and first-fetch handshake
        prog.delete();
        add(enc_i(12'h000, 5'd0, 3'd0, 5'd0, O_LUI) | {20'h20000, 5'd1, 7'd0});
        add(enc_i(12'h041, 5'd0, 3'd0, 5'd2, O_IMM));
        add(enc_s(12'h000, 5'd2, 5'd1, 3'd2));
        add(EBREAK);
        load_seq++;
        repeat (3) @(negedge clk);
        #1;
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_instr", {31'd0, mem_instr}, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_eoi", eoi, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("fetch0_valid", {31'd0, mem_valid}, 32'd1);
        check("fetch0_addr", mem_addr, 32'd0);
        check("fetch0_instr", {31'd0, mem_instr}, 32'd1);
        check("fetch0_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(posedge clk); #1;
        check("fetch0_hold", {31'd0, mem_valid}, 32'd1);
        run_until_trap("uart_trap");
        check("uart_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check("uart_addr", wr_addr[0], 32'h2000_0000);
            check("uart_byte", {24'd0, wr_data[0][7:0]}, 32'h41);
            check("uart_strb", {28'd0, wr_strb[0]}, 32'hF);
        end

        // Asynchronous reset in the middle of a fetch drops mem_valid at once
        start_run();
        @(posedge clk); #1;
        check("abort_pre", {31'd0, mem_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1 check("abort_valid", {31'd0, mem_valid}, 32'd0);

        // SB / LB / LBU lane handling
        prog.delete();
        add(enc_i(12'hF80, 5'd0, 3'd0, 5'd1, O_IMM));
        add(enc_s(12'h002, 5'd1, 5'd0, 3'd0));
        add(enc_i(12'h002, 5'd0, 3'd0, 5'd2, O_LOAD));
        add(enc_i(12'h002, 5'd0, 3'd4, 5'd3, O_LOAD));
        add(enc_s(12'h100, 5'd2, 5'd0, 3'd2));
        add(enc_s(12'h104, 5'd3, 5'd0, 3'd2));
        add(EBREAK);
        start_run();
        run_until_trap("ls_trap");
        check("ls_nwr", wr_addr.size(), 3);
        if (wr_addr.size() > 0) begin
            check("sb_addr", wr_addr[0], 32'd0);
            check("sb_strb", {28'd0, wr_strb[0]}, 32'h4);
            check("sb_wdata", wr_data[0], 32'h8080_8080);
        end
        check("lb_val", ram[15'h40], 32'hFFFF_FF80);
        check("lbu_val", ram[15'h41], 32'h0000_0080);

        // Sum 1..10 loop plus a few ALU corner cases
        prog.delete();
        add(enc_i(12'd10, 5'd0, 3'd0, 5'd1, O_IMM));
        add(enc_i(12'd0, 5'd0, 3'd0, 5'd3, O_IMM));
        add(enc_r(7'd0, 5'd1, 5'd3, 3'd0, 5'd3));
        add(enc_i(12'hFFF, 5'd1, 3'd0, 5'd1, O_IMM));
        add(enc_b(13'h1FF8, 5'd0, 5'd1, 3'd1));
        add(enc_s(12'h200, 5'd3, 5'd0, 3'd2));
        add(enc_i(12'hFF0, 5'd0, 3'd0, 5'd4, O_IMM));
        add(enc_i(12'h402, 5'd4, 3'd5, 5'd5, O_IMM));
        add(enc_i(12'd28, 5'd4, 3'd5, 5'd6, O_IMM));
        add(enc_r(7'd0, 5'd4, 5'd3, 3'd3, 5'd7));
        add(enc_r(7'h20, 5'd4, 5'd3, 3'd0, 5'd8));
        add(enc_s(12'h204, 5'd5, 5'd0, 3'd2));
        add(enc_s(12'h208, 5'd6, 5'd0, 3'd2));
        add(enc_s(12'h20C, 5'd7, 5'd0, 3'd2));
        add(enc_s(12'h210, 5'd8, 5'd0, 3'd2));
        add(EBREAK);
        start_run();
        run_until_trap("loop_trap");
        check("sum_ram", ram[15'h80], 32'd55);
        if (wr_data.size() > 0) check("sum_wdata", wr_data[0], 32'h37);
        check("srai", ram[15'h81], 32'hFFFF_FFFC);
        check("srli", ram[15'h82], 32'h0000_000F);
        check("sltu", ram[15'h83], 32'd1);
        check("sub", ram[15'h84], 32'd71);

        // EBREAK halts and freezes the bus
        prog.delete();
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd1, O_IMM));
        add(EBREAK);
        start_run();
        run_until_trap("ebreak_trap");
        check_frozen("ebreak_frozen");

        // Misaligned LW traps
        prog.delete();
        add(enc_i(12'd3, 5'd0, 3'd2, 5'd1, O_LOAD));
        start_run();
        run_until_trap("lw3_trap");
        check_frozen("lw3_frozen");
        check("lw3_nwr", wr_addr.size(), 0);

        // Illegal all-zero opcode traps
        prog.delete();
        add(32'd0);
        start_run();
        run_until_trap("illegal_trap");

`ifdef PICORV32_IRQ_EN
        begin
            logic [31:0] fa;
            logic        ok;
            prog.delete();
            add(enc_i(12'd5, 5'd0, 3'd0, 5'd1, O_IMM));
            add(32'h0000_006F);
            add(32'h0000_0013);
            add(32'h0000_0013);
            add(enc_i(12'd7, 5'd0, 3'd0, 5'd2, O_IMM));
            add(32'h3020_0073);
            start_run();
            repeat (20) @(negedge clk);
            irq = 32'd1;
            fa = 32'd0;
            ok = 1'b0;
            for (int k = 0; k < 6; k++) begin
                next_fetch(fa, ok);
                if (fa == 32'h10) break;
            end
            check("irq_vec", fa, 32'h10);
            check("irq_eoi", eoi, 32'h1);
            irq = 32'd0;
            next_fetch(fa, ok);
            check("irq_h2", fa, 32'h14);
            next_fetch(fa, ok);
            check("mret_ret", fa, 32'h4);
            check("mret_eoi", eoi, 32'd0);
            check("irq_notrap", {31'd0, trap}, 32'd0);
        end
`endif

        check("protocol", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
